// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the EX operand stage.
//   fwd_sel_t  - forwarding source per ALU operand
//   alu_srca_t - ALU operand A select encoding
//   ALU_*      - ALU operation encodings
//   id_ex_t    - ID/EX pipeline register contents
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        SRCA_RS1   = 2'b00,
        SRCA_PC    = 2'b01,
        SRCA_ZERO  = 2'b10,
        SRCA_ZERO2 = 2'b11
    } alu_srca_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef struct packed {
        logic            valid;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        alu_srca_t       alu_src_a;
        logic            alu_src_b;
        logic [3:0]      alu_control;
        logic            reg_write;
        logic            mem_read;
    } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// forward_unit: picks the forwarding source for each EX source register.
//   rs1_e/rs2_e             - EX-stage source register addresses
//   rd_m/reg_write_m        - MEM-stage destination
//   rd_w/reg_write_w        - WB-stage destination
//   fwd_a/fwd_b             - selected source per operand (MEM beats WB, x0 never forwarded)
module forward_unit
    import riscv_pkg::*;
#(
    parameter int RAW = riscv_pkg::RAW
) (
    input  logic [RAW-1:0] rs1_e,
    input  logic [RAW-1:0] rs2_e,
    input  logic [RAW-1:0] rd_m,
    input  logic           reg_write_m,
    input  logic [RAW-1:0] rd_w,
    input  logic           reg_write_w,
    output fwd_sel_t       fwd_a,
    output fwd_sel_t       fwd_b
);

    // A nonzero rd that matches rs implies rs is nonzero, so x0 is excluded here.
    logic m_ok;
    logic w_ok;

    assign m_ok  = reg_write_m && (rd_m != '0);
    assign w_ok  = reg_write_w && (rd_w != '0);
    assign fwd_a = (m_ok && rd_m == rs1_e) ? FWD_MEM : (w_ok && rd_w == rs1_e) ? FWD_WB : FWD_NONE;
    assign fwd_b = (m_ok && rd_m == rs2_e) ? FWD_MEM : (w_ok && rd_w == rs2_e) ? FWD_WB : FWD_NONE;

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register, operand forwarding and load-use hazard detection.
//   Decode inputs (*D)      - captured into the ID/EX register each cycle
//   StallE/FlushE           - hold / kill the EX slot (flush has priority)
//   RdM/RegWriteM/ALUResultM, RdW/RegWriteW/ResultW - forwarding sources
//   SrcAE/SrcBE/ALUControlE - ALU operands and operation
//   WriteDataE              - forwarded rs2 for stores
//   RdE/RegWriteE/MemReadE/ValidE - registered control for later stages
//   StallD                  - holds fetch/decode on a load-use hazard
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RAW  = riscv_pkg::RAW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic [RAW-1:0]  Rs1D,
    input  logic [RAW-1:0]  Rs2D,
    input  logic [RAW-1:0]  RdD,
    input  logic [XLEN-1:0] Rd1D,
    input  logic [XLEN-1:0] Rd2D,
    input  logic [XLEN-1:0] ImmD,
    input  logic [XLEN-1:0] PCD,
    input  logic [1:0]      ALUSrcAD,
    input  logic            ALUSrcBD,
    input  logic [3:0]      ALUControlD,
    input  logic            RegWriteD,
    input  logic            MemReadD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [RAW-1:0]  RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [RAW-1:0]  RdW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [RAW-1:0]  RdE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic            ValidE,
    output logic            StallD
);

    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            load_use;
    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic [XLEN-1:0] fwd_a_val;
    logic [XLEN-1:0] fwd_b_val;

    forward_unit #(.RAW(RAW)) u_fwd (
        .rs1_e       (ex_q.rs1),
        .rs2_e       (ex_q.rs2),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    // Rs2 is compared even when the instruction does not read it (conservative).
    assign load_use = ValidD && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D));

    // Control bits are gated by ValidD so an empty slot never writes or loads.
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (!StallE) begin
            if (load_use) begin
                ex_d = '0;
            end else begin
                ex_d.valid       = ValidD;
                ex_d.rs1         = Rs1D;
                ex_d.rs2         = Rs2D;
                ex_d.rd          = RdD;
                ex_d.rd1         = Rd1D;
                ex_d.rd2         = Rd2D;
                ex_d.imm         = ImmD;
                ex_d.pc          = PCD;
                ex_d.alu_src_a   = alu_srca_t'(ALUSrcAD);
                ex_d.alu_src_b   = ALUSrcBD;
                ex_d.alu_control = ALUControlD;
                ex_d.reg_write   = RegWriteD && ValidD;
                ex_d.mem_read    = MemReadD && ValidD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign fwd_a_val   = (fwd_a == FWD_MEM) ? ALUResultM : (fwd_a == FWD_WB) ? ResultW : ex_q.rd1;
    assign fwd_b_val   = (fwd_b == FWD_MEM) ? ALUResultM : (fwd_b == FWD_WB) ? ResultW : ex_q.rd2;
    assign SrcAE       = (ex_q.alu_src_a == SRCA_RS1) ? fwd_a_val :
                         (ex_q.alu_src_a == SRCA_PC)  ? ex_q.pc   : '0;
    assign SrcBE       = ex_q.alu_src_b ? ex_q.imm : fwd_b_val;
    assign WriteDataE  = fwd_b_val;
    assign ALUControlE = ex_q.alu_control;
    assign RdE         = ex_q.rd;
    assign RegWriteE   = ex_q.reg_write;
    assign MemReadE    = ex_q.mem_read;
    assign ValidE      = ex_q.valid;
    // A flushed slot never stalls decode.
    assign StallD      = load_use && !FlushE;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [31:0] Rd1D, Rd2D, ImmD, PCD;
    logic [1:0]  ALUSrcAD;
    logic        ALUSrcBD;
    logic [3:0]  ALUControlD;
    logic        RegWriteD, MemReadD, StallE, FlushE;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic [3:0]  ALUControlE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, ValidE, StallD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .Rd1D(Rd1D), .Rd2D(Rd2D), .ImmD(ImmD), .PCD(PCD), .ALUSrcAD(ALUSrcAD),
        .ALUSrcBD(ALUSrcBD), .ALUControlD(ALUControlD), .RegWriteD(RegWriteD),
        .MemReadD(MemReadD), .StallE(StallE), .FlushE(FlushE), .RdM(RdM),
        .RegWriteM(RegWriteM), .ALUResultM(ALUResultM), .RdW(RdW), .RegWriteW(RegWriteW),
        .ResultW(ResultW), .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
        .ValidE(ValidE), .StallD(StallD)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ValidD = 0; Rs1D = 0; Rs2D = 0; RdD = 0; Rd1D = 0; Rd2D = 0; ImmD = 0; PCD = 0;
        ALUSrcAD = 0; ALUSrcBD = 0; ALUControlD = 0; RegWriteD = 0; MemReadD = 0;
        StallE = 0; FlushE = 0; RdM = 0; RegWriteM = 0; ALUResultM = 0;
        RdW = 0; RegWriteW = 0; ResultW = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        clear_inputs();
        ValidD = 1; MemReadD = 1; RegWriteD = 1; RdD = rd; Rs1D = 5'd1; Rd1D = 32'h1000;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ValidE); end
        checks++; if (ALUControlE !== 4'b0000) begin errors++; $display("FAIL reset_aluctl got=%h exp=0", ALUControlE); end
        rst_n = 1;
        drive_load(5'd5);
        ImmD = 32'hFFFF; ALUSrcBD = 1;
        tick();
        Rs1D = 5'd5; ValidD = 1; MemReadD = 0; ALUSrcBD = 0;
        #1;
        checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL reset_pre_stall got=%b exp=1", StallD); end
        #2 rst_n = 0;
        #1;
        checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL reset_async_valid got=%b exp=0", ValidE); end
        checks++; if (SrcAE !== 32'h0) begin errors++; $display("FAIL reset_async_srca got=%h exp=0", SrcAE); end
        checks++; if (SrcBE !== 32'h0) begin errors++; $display("FAIL reset_async_srcb got=%h exp=0", SrcBE); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL reset_async_stalld got=%b exp=0", StallD); end
        checks++; if (MemReadE !== 1'b0 || RegWriteE !== 1'b0 || RdE !== 5'd0) begin errors++; $display("FAIL reset_async_ctrl got=%b%b%h exp=000", MemReadE, RegWriteE, RdE); end
        tick();
        rst_n = 1;
        clear_inputs();
        tick();
    endtask

    task automatic test_plain_and_muxes();
        clear_inputs();
        ValidD = 1; Rs1D = 1; Rs2D = 2; RdD = 3; Rd1D = 5; Rd2D = 7; RegWriteD = 1;
        tick();
        checks++; if (SrcAE !== 32'd5) begin errors++; $display("FAIL add_srca got=%h exp=5", SrcAE); end
        checks++; if (SrcBE !== 32'd7) begin errors++; $display("FAIL add_srcb got=%h exp=7", SrcBE); end
        checks++; if (ALUControlE !== 4'd0) begin errors++; $display("FAIL add_aluctl got=%h exp=0", ALUControlE); end
        checks++; if (RdE !== 5'd3 || RegWriteE !== 1'b1 || ValidE !== 1'b1) begin errors++; $display("FAIL add_ctrl got rd=%h rw=%b v=%b exp rd=3 rw=1 v=1", RdE, RegWriteE, ValidE); end
        checks++; if (WriteDataE !== 32'd7) begin errors++; $display("FAIL add_wdata got=%h exp=7", WriteDataE); end
        ALUSrcAD = 2'b01; ALUSrcBD = 1; PCD = 32'h400; ImmD = 32'h100; ALUControlD = 4'b0001;
        tick();
        checks++; if (SrcAE !== 32'h400) begin errors++; $display("FAIL pc_srca got=%h exp=400", SrcAE); end
        checks++; if (SrcBE !== 32'h100) begin errors++; $display("FAIL imm_srcb got=%h exp=100", SrcBE); end
        checks++; if (WriteDataE !== 32'd7) begin errors++; $display("FAIL imm_wdata got=%h exp=7", WriteDataE); end
        checks++; if (ALUControlE !== 4'b0001) begin errors++; $display("FAIL sub_aluctl got=%h exp=1", ALUControlE); end
        ALUSrcAD = 2'b10;
        tick();
        checks++; if (SrcAE !== 32'h0) begin errors++; $display("FAIL zero_srca got=%h exp=0", SrcAE); end
        ALUSrcAD = 2'b11;
        tick();
        checks++; if (SrcAE !== 32'h0) begin errors++; $display("FAIL zero2_srca got=%h exp=0", SrcAE); end
        ValidD = 0;
        tick();
        checks++; if (ValidE !== 1'b0 || RegWriteE !== 1'b0) begin errors++; $display("FAIL invalid_gate got v=%b rw=%b exp 0 0", ValidE, RegWriteE); end
    endtask

    task automatic test_forward();
        clear_inputs();
        ValidD = 1; Rs1D = 1; Rs2D = 2; RdD = 4; Rd1D = 32'hAA; Rd2D = 32'hBB;
        tick();
        RdM = 1; RegWriteM = 1; ALUResultM = 32'h10; RdW = 1; RegWriteW = 1; ResultW = 32'h20;
        #1;
        checks++; if (SrcAE !== 32'h10) begin errors++; $display("FAIL fwd_mem_a got=%h exp=10", SrcAE); end
        checks++; if (SrcBE !== 32'hBB) begin errors++; $display("FAIL fwd_none_b got=%h exp=bb", SrcBE); end
        RegWriteM = 0;
        #1;
        checks++; if (SrcAE !== 32'h20) begin errors++; $display("FAIL fwd_wb_a got=%h exp=20", SrcAE); end
        RdM = 2; RegWriteM = 1; RdW = 2;
        #1;
        checks++; if (SrcBE !== 32'h10 || WriteDataE !== 32'h10) begin errors++; $display("FAIL fwd_mem_b got=%h/%h exp=10", SrcBE, WriteDataE); end
        checks++; if (SrcAE !== 32'hAA) begin errors++; $display("FAIL fwd_a_unmatched got=%h exp=aa", SrcAE); end
        RegWriteM = 0;
        #1;
        checks++; if (WriteDataE !== 32'h20) begin errors++; $display("FAIL fwd_wb_b got=%h exp=20", WriteDataE); end
        Rs1D = 0; Rs2D = 0; Rd1D = 32'h33; Rd2D = 32'h44;
        RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1;
        tick();
        checks++; if (SrcAE !== 32'h33) begin errors++; $display("FAIL fwd_x0_a got=%h exp=33", SrcAE); end
        checks++; if (SrcBE !== 32'h44) begin errors++; $display("FAIL fwd_x0_b got=%h exp=44", SrcBE); end
    endtask

    task automatic test_load_use();
        drive_load(5'd5);
        tick();
        checks++; if (MemReadE !== 1'b1 || RdE !== 5'd5) begin errors++; $display("FAIL lu_load_in_e got mr=%b rd=%h exp 1 5", MemReadE, RdE); end
        clear_inputs();
        ValidD = 1; Rs1D = 6; Rs2D = 5; RdD = 7; Rd1D = 32'h11; Rd2D = 32'h22; RegWriteD = 1;
        #1;
        checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL lu_stalld got=%b exp=1", StallD); end
        tick();
        checks++; if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || MemReadE !== 1'b0 || RdE !== 5'd0) begin errors++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b rd=%h exp 0 0 0 0", ValidE, RegWriteE, MemReadE, RdE); end
        checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%b exp=0", StallD); end
        tick();
        checks++; if (ValidE !== 1'b1 || RdE !== 5'd7 || SrcAE !== 32'h11) begin errors++; $display("FAIL lu_capture got v=%b rd=%h a=%h exp 1 7 11", ValidE, RdE, SrcAE); end
        drive_load(5'd0);
        tick();
        clear_inputs();
        ValidD = 1; Rs1D = 0; Rs2D = 0;
        #1;
        checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_x0_nostall got=%b exp=0", StallD); end
        drive_load(5'd8);
        tick();
        clear_inputs();
        ValidD = 0; Rs1D = 8;
        #1;
        checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL lu_invalid_d_nostall got=%b exp=0", StallD); end
        ValidD = 1;
        #1;
        checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL lu_rs1_stall got=%b exp=1", StallD); end
        tick();
    endtask

    task automatic test_flush();
        drive_load(5'd5);
        tick();
        clear_inputs();
        ValidD = 1; Rs1D = 5; RdD = 9; RegWriteD = 1; FlushE = 1;
        #1;
        checks++; if (StallD !== 1'b0) begin errors++; $display("FAIL flush_stalld got=%b exp=0", StallD); end
        tick();
        checks++; if (ValidE !== 1'b0 || RegWriteE !== 1'b0) begin errors++; $display("FAIL flush_kill got v=%b rw=%b exp 0 0", ValidE, RegWriteE); end
        FlushE = 0;
        tick();
        checks++; if (ValidE !== 1'b1 || RdE !== 5'd9) begin errors++; $display("FAIL flush_resume got v=%b rd=%h exp 1 9", ValidE, RdE); end
        StallE = 1; FlushE = 1;
        tick();
        checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL flush_over_stall got=%b exp=0", ValidE); end
        clear_inputs();
    endtask

    task automatic test_stall_e();
        clear_inputs();
        ValidD = 1; Rs1D = 3; RdD = 9; Rd1D = 32'h55; ALUControlD = 4'b0100; RegWriteD = 1;
        tick();
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            Rd1D = 32'h100 + i; RdD = 5'(10 + i); ALUControlD = 4'(i);
            tick();
            checks++; if (SrcAE !== 32'h55 || RdE !== 5'd9 || ALUControlE !== 4'b0100) begin errors++; $display("FAIL stalle_hold%0d got a=%h rd=%h op=%h exp 55 9 4", i, SrcAE, RdE, ALUControlE); end
        end
        StallE = 0;
        tick();
        checks++; if (SrcAE !== 32'h102 || RdE !== 5'd12 || ALUControlE !== 4'd2) begin errors++; $display("FAIL stalle_release got a=%h rd=%h op=%h exp 102 c 2", SrcAE, RdE, ALUControlE); end
        drive_load(5'd5);
        tick();
        clear_inputs();
        ValidD = 1; Rs1D = 5; StallE = 1;
        tick();
        checks++; if (ValidE !== 1'b1 || MemReadE !== 1'b1 || RdE !== 5'd5) begin errors++; $display("FAIL stalle_lu_hold got v=%b mr=%b rd=%h exp 1 1 5", ValidE, MemReadE, RdE); end
        checks++; if (StallD !== 1'b1) begin errors++; $display("FAIL stalle_lu_stalld got=%b exp=1", StallD); end
        StallE = 0;
        tick();
        checks++; if (ValidE !== 1'b0) begin errors++; $display("FAIL stalle_lu_bubble got=%b exp=0", ValidE); end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_plain_and_muxes();
        test_forward();
        test_load_use();
        test_flush();
        test_stall_e();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
